gpu_scroll_rx: RTL
==================

# gpu_scroll_rx

Receiving end of the scrolling-ID display bus. The GPU block rotates a 32-bit ID left by one nibble per clk3hz tick and exposes the upper 16 bits on a 16-bit data bus. This block samples that bus on the same clock, reconstructs the full 32-bit ID, then keeps checking every later window against the recovered value. It reports recovered ID, lock, and a sticky error. It shares rst with the GPU block, so the two stay phase-aligned without a sync marker.

## Interface
- LOCK_CYCLES, default 8: number of consecutive matching windows after recovery before locked asserts; range 1..255.
- clk3hz  in  1  system clock, shared with the GPU block; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- dataBus  in  16  GPU window (registered output of the GPU, rotl(ID, 4k)[31:16]).
- id_out  out  32  recovered ID; 0 until id_valid.
- id_valid  out  1  id_out is complete.
- locked  out  1  LOCK_CYCLES consecutive windows matched after recovery.
- err  out  1  sticky mismatch flag; cleared only by rst.
- phase  out  3  rotation index k of the window sampled at the last edge, mod 8.

## Operation
- Cycle n = nth posedge with rst high, counting from n=1. At cycle n the block samples W(n-1) = rotl(ID, 4(n-1))[31:16].
- States: ACQ, TRACK, LOCK, ERR. Reset enters ACQ.
- ACQ, cycle 1: shift register sr[31:16] <= dataBus.
- ACQ, cycles 2..5: sr[15:12], [11:8], [7:4], [3:0] <= dataBus[3:0], in that order.
- ACQ overlap check, cycles 2..5: dataBus[15:4] must equal prev[11:0], where prev is the previous sample. On mismatch: err <= 1, go to ERR.
- ACQ exit: at cycle 5 with no mismatch, id_out <= assembled ID, id_valid <= 1, go to TRACK, match counter <= 0.
- TRACK/LOCK: each cycle compute exp = rotl(id_out, 4·phase_next)[31:16] and compare with dataBus.
  - TRACK, match: counter increments; reaching LOCK_CYCLES sets locked and goes to LOCK.
  - LOCK, match: stay in LOCK.
  - TRACK or LOCK, mismatch: err <= 1, locked <= 0, go to ERR.
- ERR: terminal until rst. id_out and id_valid hold their values; phase keeps counting.
- phase: 0 at reset. Becomes 0 at cycle 1, then increments mod 8 every cycle; wraps 7→0.
- Arithmetic: rotation by 4·phase uses a 3-bit index, so the full period is 8 windows. Match counter is 8 bits and saturates at LOCK_CYCLES.

## Timing
- All outputs are registered. Reset values: id_out=0, id_valid=0, locked=0, err=0, phase=0.
- id_valid rises after the cycle-5 edge (5 cycles of latency from reset release).
- locked rises after edge 5+LOCK_CYCLES; with the default that is cycle 13.
- err rises on the edge that samples the first bad window.
- rst low at any edge overrides everything: all state returns to reset values on that edge. This includes mid-ACQ and ERR.
- The GPU reloads its ID on the same reset edge, so re-acquisition restarts cleanly at the next cycle 1.
- A degenerate ID (all nibbles equal, e.g. 0xAAAAAAAA) is valid and locks normally.
- A bus value of 0 during ACQ is legal data, not a "no data" indication.

## Structure
- Shared package:
  - state encoding constants ST_ACQ, ST_TRACK, ST_LOCK, ST_ERR;
  - NIB_W=4, BUS_W=16, ID_W=32, PERIOD=8.
  The GPU block reuses the width constants.
- One sub-module, gpu_rot_window: combinational rotl(id, 4·k)[31:16] for a 3-bit k. Used for the expected-window compare; the bench model uses it too.

## Test plan
- ID 0x12345678, clean reset → windows sampled 1234, 2345, 3456, 4567, 5678. id_valid=1 and id_out=0x12345678 after cycle 5; locked=1 after cycle 13; err stays 0 over 40 cycles; phase wraps 7→0 at cycle 9.
- Force dataBus=0x2355 at cycle 2 (overlap fails, expected 0x2345) → err=1 after cycle 2; id_valid stays 0; state ERR.
- Lock on 0x12345678, then force a single bad window 0x8124 at cycle 20 → err=1 and locked=0 after cycle 20; id_out holds 0x12345678.
- Assert rst for one edge at cycle 3, then release with ID 0xDEADBEEF → all outputs reset on that edge; re-acquires; id_out=0xDEADBEEF and id_valid=1 at new cycle 5.
- ID 0xAAAAAAAA with LOCK_CYCLES=1 → every window is 0xAAAA; id_valid=1 after cycle 5; locked=1 after cycle 6.
- Reset held low for 10 edges → all outputs stay at reset values throughout; phase stays 0.

Source files
------------

// File: rtl/gpu_scroll_rx_pkg.sv
// Shared constants for the scrolling-ID display bus (GPU side and receiver).
package gpu_scroll_rx_pkg;

    localparam int NIB_W  = 4;
    localparam int BUS_W  = 16;
    localparam int ID_W   = 32;
    localparam int PERIOD = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_ACQ   = 2'd0;
    localparam state_t ST_TRACK = 2'd1;
    localparam state_t ST_LOCK  = 2'd2;
    localparam state_t ST_ERR   = 2'd3;

endpackage

// File: rtl/gpu_rot_window.sv
// Combinational window extraction: rotl(id, 4*k)[31:16] for a 3-bit rotation index.
module gpu_rot_window
    import gpu_scroll_rx_pkg::*;
(
    input  logic [ID_W-1:0]  id,
    input  logic [2:0]       k,
    output logic [BUS_W-1:0] win
);

    logic [2*ID_W-1:0] dbl;

    // Doubling the word turns the rotate into a plain shift of the upper half.
    always_comb begin
        dbl = {id, id} << {k, 2'b00};
        win = dbl[2*ID_W-1 -: BUS_W];
    end

endmodule

// File: rtl/gpu_scroll_rx.sv
// Scrolling-ID receiver: recovers the 32-bit ID from five windows, then
// tracks every later window against it, reporting lock and a sticky error.
module gpu_scroll_rx
    import gpu_scroll_rx_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 8
) (
    input  logic             clk3hz,
    input  logic             rst,
    input  logic [BUS_W-1:0] dataBus,
    output logic [ID_W-1:0]  id_out,
    output logic             id_valid,
    output logic             locked,
    output logic             err,
    output logic [2:0]       phase
);

    localparam logic [7:0] LOCK_N = 8'(LOCK_CYCLES);

    state_t                state;
    logic [ID_W-1:NIB_W]   sr;
    logic [BUS_W-1:0]      prev;
    logic [2:0]            acqCnt;
    logic [7:0]            matchCnt;
    logic [2:0]            phaseNext;
    logic [BUS_W-1:0]      expWin;
    logic                  overlapOk;
    logic                  winMatch;

    // The first sample after reset is window 0; every later edge advances by one.
    always_comb begin
        phaseNext = (state == ST_ACQ && acqCnt == 3'd0) ? 3'd0 : phase + 3'd1;
        overlapOk = (dataBus[BUS_W-1:NIB_W] == prev[BUS_W-NIB_W-1:0]);
        winMatch  = (dataBus == expWin);
    end

    gpu_rot_window u_win (
        .id  (id_out),
        .k   (phaseNext),
        .win (expWin)
    );

    always_ff @(posedge clk3hz) begin
        if (!rst) begin
            state    <= ST_ACQ;
            sr       <= '0;
            prev     <= '0;
            acqCnt   <= '0;
            matchCnt <= '0;
            id_out   <= '0;
            id_valid <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
            phase    <= '0;
        end else begin
            phase <= phaseNext;
            prev  <= dataBus;
            case (state)
                ST_ACQ: begin
                    if (acqCnt == 3'd0) begin
                        sr[ID_W-1:BUS_W] <= dataBus;
                        acqCnt           <= 3'd1;
                    end else if (!overlapOk) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        acqCnt <= acqCnt + 3'd1;
                        case (acqCnt)
                            3'd1:    sr[15:12] <= dataBus[NIB_W-1:0];
                            3'd2:    sr[11:8]  <= dataBus[NIB_W-1:0];
                            3'd3:    sr[7:4]   <= dataBus[NIB_W-1:0];
                            default: begin
                                id_out   <= {sr, dataBus[NIB_W-1:0]};
                                id_valid <= 1'b1;
                                matchCnt <= '0;
                                state    <= ST_TRACK;
                            end
                        endcase
                    end
                end
                ST_TRACK: begin
                    if (!winMatch) begin
                        err    <= 1'b1;
                        locked <= 1'b0;
                        state  <= ST_ERR;
                    end else if (matchCnt + 8'd1 >= LOCK_N) begin
                        matchCnt <= LOCK_N;
                        locked   <= 1'b1;
                        state    <= ST_LOCK;
                    end else begin
                        matchCnt <= matchCnt + 8'd1;
                    end
                end
                ST_LOCK: begin
                    if (!winMatch) begin
                        err    <= 1'b1;
                        locked <= 1'b0;
                        state  <= ST_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
